bcd_cascade_counter: RTL and testbench
======================================

# bcd_cascade_counter

Parametrised multi-digit BCD counter, the successor to the single-digit mod-10 button counter used in the digital clock/lock datapath. It chains `DIGITS` BCD digits, with a configurable modulus on the most significant digit, so one instance covers seconds, minutes, or code-entry fields. It counts up or down on step events, supports synchronous clear and parallel load, and flags wrap-around. It runs on the system clock; button input is conditioned internally instead of being used as a clock.

## Interface

Parameters:
- `DIGITS`, 4: number of cascaded BCD digits; legal range 1..8.
- `TOP_MOD`, 10: modulus of the most significant digit; legal range 2..10. All lower digits are mod 10.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn` input 1: raw push-button step request.
- `inc` input 1: synchronous step request, one step per cycle while high.
- `up_dn` input 1: count direction; 1 counts up, 0 counts down. Sampled on the step cycle.
- `clr` input 1: synchronous clear to zero.
- `load` input 1: synchronous parallel load.
- `load_val` input 4*DIGITS: BCD load value; digit 0 occupies bits [3:0].
- `digits` output 4*DIGITS: current count in BCD; digit 0 is least significant.
- `carry` output 1: one-cycle pulse on wrap (max→0 going up, 0→max going down).
- `at_zero` output 1: high while every digit is 0.

## Operation

- Max count is `TOP_MOD-1` in the top digit and 9 in every lower digit. Total modulus is `TOP_MOD*10^(DIGITS-1)`.
- Step event: `step = inc | btn_evt`. Both sources asserting in the same cycle produce a single step.
- Per-cycle priority: `clr` > `load` > step > hold.
  - `clr`: all digits become 0 and `carry` becomes 0.
  - `load`: each digit takes its `load_val` field. A digit field >9, or a top field ≥`TOP_MOD`, loads as 0. `carry` becomes 0.
  - Step up: digit 0 increments. A digit at its max becomes 0 and propagates carry to the next digit.
  - Step down: digit 0 decrements. A digit at 0 becomes its max and propagates borrow to the next digit.
- `carry` is registered. It is 1 in the cycle following a step whose ripple leaves the top digit, and 0 otherwise.
- `at_zero` is combinational from the digit registers.
- With `DIGITS=1`, the single digit uses `TOP_MOD` as its modulus.

## Timing

- Reset values: `digits`=0, `carry`=0, `at_zero`=1. All internal synchroniser and edge flops are 0.
- `inc`, `clr`, and `load` have one-cycle latency: the new value appears after the next rising edge.
- `btn` latency depends on the configuration (see below).
- The full ripple through all digits completes within one cycle; there are no multi-cycle paths.
- If `rst_n` is asserted mid-count, outputs clear immediately and asynchronously. A step pending in the synchroniser is discarded.
- Reset deassertion must be synchronised externally to `clk`.

## Configuration

- `BCD_CNT_BTN_SYNC_EN` defined:
  - `btn` passes through a 2-flop synchroniser and a rising-edge detector.
  - `btn_evt` is a single-cycle pulse per press.
  - The count updates 3 rising edges after `btn` rises.
  - Holding `btn` high yields exactly one step.
- `BCD_CNT_BTN_SYNC_EN` undefined:
  - `btn` is treated as already synchronous, and `btn_evt = btn`.
  - One-cycle latency; one step per cycle while `btn` is high.

## Structure

- Package `bcd_cnt_pkg` contains:
  - the `bcd_t` 4-bit digit typedef;
  - constants `BCD_MAX=4'd9` and `BCD_ZERO=4'd0`;
  - the function `bcd_sanitize(value, mod)` used for load.
- Sub-module `bcd_digit`: one digit register with parameter `MOD`. Its inputs are `step_in`, `up_dn`, `clr`, `load`, and `load_d`. Its outputs are `q` and `ripple_out`.
  - Instantiated `DIGITS` times in a generate loop.
  - Each digit's `ripple_out` drives the next digit's `step_in`.
  - The top instance uses `MOD=TOP_MOD`; all others use 10.
- The top level holds the `btn` conditioning, step OR, and `carry` register.

## Test plan

- Reset, then 10 `inc` pulses with `up_dn`=1, `DIGITS`=2: `digits` = 0x10, `carry` stays 0.
- `DIGITS`=2, `TOP_MOD`=6, load 0x59, one up-step: `digits`=0x00, `carry`=1 for one cycle, `at_zero`=1.
- At 0x00, one down-step with `DIGITS`=2, `TOP_MOD`=6: `digits`=0x59, `carry` pulses once.
- Same cycle `clr`=1, `load`=1 with 0x42, `inc`=1: `digits`=0x00. Then `load` alone with 0x4A yields 0x40 (invalid field zeroed).
- With `BCD_CNT_BTN_SYNC_EN` defined, `btn` held high for 20 cycles: exactly one increment, visible 3 edges after the rise. Without the macro: 20 increments.
- Assert `rst_n`=0 mid-sequence at 0x37 with `btn` in the synchroniser: `digits`=0 immediately, and no step after release.

Source files
------------

// File: rtl/bcd_cnt_pkg.sv
// rtl/bcd_cnt_pkg.sv - shared BCD digit type, constants and load sanitiser
//
// Purpose : common definitions for the cascaded BCD counter.
// Contents: bcd_t digit type, BCD_MAX / BCD_ZERO constants,
//           bcd_sanitize(value, mod) which forces an out-of-range digit to 0.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // A digit value is legal only when it is below the digit's modulus.
  // Anything else (including the non-BCD codes A..F) loads as zero.
  function automatic bcd_t bcd_sanitize(input bcd_t value, input int mod);
    if (int'({28'd0, value}) >= mod)
      return BCD_ZERO;
    else
      return value;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit register with up/down ripple
//
// Purpose : one counter digit of modulus MOD (2..10).
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           step_in         - step request from the digit below (or the step source)
//           up_dn           - 1 counts up, 0 counts down
//           clr, load       - synchronous clear / parallel load (clr wins)
//           load_d          - value for load, sanitised against MOD
//           q               - current digit value
//           ripple_out      - combinational carry/borrow into the next digit
module bcd_digit
  import bcd_cnt_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_in,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] q,
  output logic       ripple_out
);

  localparam bcd_t MAXV = bcd_t'(MOD - 1);

  logic at_max;
  logic at_min;

  assign at_max = (q == MAXV);
  assign at_min = (q == BCD_ZERO);

  // Ripple is only meaningful when this digit steps; clr/load override it
  // in every digit, so it need not be gated by them here.
  assign ripple_out = step_in & (up_dn ? at_max : at_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else if (clr) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= bcd_sanitize(load_d, MOD);
    end else if (step_in) begin
      if (up_dn)
        q <= at_max ? BCD_ZERO : q + 4'd1;
      else
        q <= at_min ? MAXV : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - parametrised multi-digit BCD up/down counter
//
// Purpose : DIGITS cascaded BCD digits, top digit mod TOP_MOD, others mod 10.
//           Counts on inc or a button event; clear > load > step > hold.
// Ports   : clk, rst_n   - system clock, asynchronous active-low reset
//           btn          - raw push-button step request
//           inc          - synchronous step request (one step per cycle)
//           up_dn        - count direction (1 = up)
//           clr, load    - synchronous clear / parallel load
//           load_val     - BCD load value, digit 0 in [3:0]
//           digits       - current count, digit 0 least significant
//           carry        - registered one-cycle wrap pulse
//           at_zero      - high while all digits are zero
// Config  : BCD_CNT_BTN_SYNC_EN - when defined, btn goes through a 2-flop
//           synchroniser and rising-edge detector (one step per press);
//           otherwise btn is used directly as a synchronous step level.
module bcd_cascade_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TOP_MOD = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn,
  input  logic                inc,
  input  logic                up_dn,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] digits,
  output logic                carry,
  output logic                at_zero
);

  logic btn_evt;
  logic step;

`ifdef BCD_CNT_BTN_SYNC_EN
  logic btn_s1;
  logic btn_s2;
  logic btn_d;

  // Two synchroniser stages then one history flop; the event fires on the
  // cycle the synchronised level first reads high, so the count moves on
  // the third rising edge after btn rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign btn_evt = btn_s2 & ~btn_d;
`else
  assign btn_evt = btn;
`endif

  assign step = inc | btn_evt;

  // ripple[i] is the step into digit i; ripple[DIGITS] leaves the top digit.
  logic [DIGITS:0] ripple;
  assign ripple[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int DMOD = (i == DIGITS - 1) ? TOP_MOD : 10;

    bcd_digit #(
      .MOD(DMOD)
    ) u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .step_in   (ripple[i]),
      .up_dn     (up_dn),
      .clr       (clr),
      .load      (load),
      .load_d    (load_val[4*i +: 4]),
      .q         (digits[4*i +: 4]),
      .ripple_out(ripple[i+1])
    );
  end

  // Wrap pulse: only a real step can set it; clr and load always clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      carry <= 1'b0;
    else if (clr || load)
      carry <= 1'b0;
    else
      carry <= ripple[DIGITS];
  end

  assign at_zero = (digits == '0);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - directed self-checking bench for bcd_cascade_counter
module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       inc;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] digits;
  logic       carry;
  logic       at_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(
    .DIGITS (2),
    .TOP_MOD(6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .inc     (inc),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .digits  (digits),
    .carry   (carry),
    .at_zero (at_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    btn      = 1'b0;
    inc      = 1'b0;
    up_dn    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    tick();
    tick();
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_at_zero", 32'(at_zero), 32'h1);
    rst_n = 1'b1;
    tick();

    // ten up steps: 00 -> 10, no wrap
    inc = 1'b1;
    tick();
    chk("inc_latency", 32'(digits), 32'h01);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("inc_no_carry", 32'(carry), 32'h0);
    end
    inc = 1'b0;
    chk("inc10_digits", 32'(digits), 32'h10);
    chk("inc10_at_zero", 32'(at_zero), 32'h0);

    // load max (59 for mod 60), wrap up
    load = 1'b1; load_val = 8'h59;
    tick();
    load = 1'b0;
    chk("load59", 32'(digits), 32'h59);
    inc = 1'b1; up_dn = 1'b1;
    tick();
    inc = 1'b0;
    chk("wrap_up_digits", 32'(digits), 32'h00);
    chk("wrap_up_carry", 32'(carry), 32'h1);
    chk("wrap_up_at_zero", 32'(at_zero), 32'h1);
    tick();
    chk("wrap_up_carry_clear", 32'(carry), 32'h0);

    // wrap down 00 -> 59
    inc = 1'b1; up_dn = 1'b0;
    tick();
    inc = 1'b0;
    chk("wrap_dn_digits", 32'(digits), 32'h59);
    chk("wrap_dn_carry", 32'(carry), 32'h1);
    tick();
    chk("wrap_dn_carry_clear", 32'(carry), 32'h0);

    // clr beats load beats step
    clr = 1'b1; load = 1'b1; load_val = 8'h42; inc = 1'b1; up_dn = 1'b1;
    tick();
    clr = 1'b0; inc = 1'b0;
    chk("clr_priority", 32'(digits), 32'h00);
    load_val = 8'h4A;
    tick();
    chk("load_bad_low", 32'(digits), 32'h40);
    load_val = 8'h73;
    tick();
    chk("load_bad_top", 32'(digits), 32'h03);
    load_val = 8'h21; inc = 1'b1;
    tick();
    load = 1'b0; inc = 1'b0;
    chk("load_over_step", 32'(digits), 32'h21);

    // borrow across digits 40 -> 39
    load = 1'b1; load_val = 8'h40;
    tick();
    load = 1'b0; inc = 1'b1; up_dn = 1'b0;
    tick();
    inc = 1'b0; up_dn = 1'b1;
    chk("borrow_digits", 32'(digits), 32'h39);
    chk("borrow_no_carry", 32'(carry), 32'h0);

    // button held 20 cycles
    clr = 1'b1;
    tick();
    clr = 1'b0;
    btn = 1'b1;
    tick();
`ifdef BCD_CNT_BTN_SYNC_EN
    chk("btn_edge1", 32'(digits), 32'h00);
    tick();
    chk("btn_edge2", 32'(digits), 32'h00);
    tick();
    chk("btn_edge3", 32'(digits), 32'h01);
    repeat (17) tick();
    chk("btn_held20", 32'(digits), 32'h01);
`else
    chk("btn_edge1", 32'(digits), 32'h01);
    repeat (19) tick();
    chk("btn_held20", 32'(digits), 32'h20);
`endif
    btn = 1'b0;
    repeat (4) tick();

    // async reset with a press in flight
    load = 1'b1; load_val = 8'h37;
    tick();
    load = 1'b0;
    btn = 1'b1;
    tick();
`ifdef BCD_CNT_BTN_SYNC_EN
    chk("pre_rst", 32'(digits), 32'h37);
`else
    chk("pre_rst", 32'(digits), 32'h38);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'h00);
    chk("async_rst_at_zero", 32'(at_zero), 32'h1);
    btn = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_step", 32'(digits), 32'h00);
    chk("post_rst_carry", 32'(carry), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
